// File: rtl/instr_loader.sv
// instr_loader: writer side of the 256x8 instruction memory.
// Accepts a framed byte stream (SYNC_BYTE, LEN, LEN data bytes, optional CSUM),
// writes the image through the memory write port, and holds the CPU in reset
// while a load is in progress.
// Optional feature: define LOADER_CHECKSUM_EN to require and check a trailing
// checksum byte (sum of data bytes + CSUM must be 0 mod 256).
module instr_loader #(
  parameter logic [7:0]  BASE_ADDR      = 8'h00,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int unsigned   TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state;
  logic [8:0]    remain;
  logic [TW-1:0] idle_cnt;
  logic          accept;
  logic          counting;
  logic          timed_out;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // Handshake, timeout-window membership and expiry decode.
  always_comb begin
    accept    = rx_valid && rx_ready;
    counting  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    timed_out = TO_EN && (idle_cnt >= TO_LAST);
  end

  // Frame FSM with registered outputs, byte counter, idle timer and checksum.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rx_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      remain    <= '0;
      idle_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept && rx_data == SYNC_BYTE) begin
            state    <= S_LEN;
            cpu_hold <= 1'b1;
            load_err <= 1'b0;
            mem_addr <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_LEN: begin
          if (accept) begin
            remain <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_wdata <= rx_data;
            rx_ready  <= 1'b0;
            state     <= S_WRITE;
`ifdef LOADER_CHECKSUM_EN
            csum      <= csum + rx_data;
`endif
          end
        end
        // mem_addr already holds BASE_ADDR+index during the write; advance it afterwards.
        S_WRITE: begin
          mem_addr <= mem_addr + 8'd1;
          remain   <= remain - 9'd1;
          if (remain == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state    <= S_CSUM;
            rx_ready <= 1'b1;
`else
            state     <= S_DONE;
            load_done <= 1'b1;
`endif
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (8'(csum + rx_data) == 8'h00) begin
              state     <= S_DONE;
              load_done <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end
        end
`endif
        S_DONE: begin
          cpu_hold <= 1'b0;
          rx_ready <= 1'b1;
          state    <= S_IDLE;
        end
        S_ERR: begin
          load_err <= 1'b1;
          rx_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b1;
        end
      endcase

      // An accepted byte always beats a timeout expiring in the same cycle.
      if (counting && !accept && timed_out) begin
        state    <= S_ERR;
        rx_ready <= 1'b0;
      end

      if (accept || !(counting || state == S_WRITE) || (counting && timed_out)) begin
        idle_cnt <= '0;
      end else if (TO_EN) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed frames plus randomized frames,
// compared against a frame-level reference model (expected write list, outcome).
module tb_instr_loader;

  localparam logic [7:0] BASE = 8'h00;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int unsigned TO  = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  always #5 clock = ~clock;

  instr_loader #(
    .BASE_ADDR     (BASE),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] obs[$];
  int          done_cnt = 0;
  logic [7:0]  payload[$];

  // Record every memory write and every done pulse, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_we) obs.push_back({mem_addr, mem_wdata});
      if (load_done) begin
        done_cnt++;
        check("hold_at_done", {31'd0, cpu_hold}, 32'd1);
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  // Offer one byte from a negedge; transfer happens at the next posedge with rx_ready high.
  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (n >= 64) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},  {31'd0, rx_ready},  32'd1);
    check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
    check({tag, "_mem_addr"},  {24'd0, mem_addr},  {24'd0, BASE});
    check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_cpu_hold"},  {31'd0, cpu_hold},  32'd0);
    check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_load_err"},  {31'd0, load_err},  32'd0);
  endtask

  // Send a whole frame built from payload and compare against the frame-level model.
  task automatic run_frame(input logic [7:0] len_field, input bit corrupt);
    int unsigned sum = 0;
    int unsigned n;
    bit          ok;
    logic [7:0]  cs;
    logic [7:0]  a;
    obs.delete();
    done_cnt = 0;
    send(SYNC);
    send(len_field);
    check("hold_in_frame", {31'd0, cpu_hold}, 32'd1);
    foreach (payload[i]) begin
      idle($urandom_range(0, 3));
      send(payload[i]);
      sum += payload[i];
    end
`ifdef LOADER_CHECKSUM_EN
    cs = 8'(32'd0 - sum) + (corrupt ? 8'h7F : 8'h00);
    ok = !corrupt;
    idle($urandom_range(0, 3));
    send(cs);
`else
    cs = 8'h00;
    ok = 1'b1;
`endif
    idle(4);
    n = payload.size();
    check("n_writes", obs.size(), n);
    for (int unsigned i = 0; i < n && i < obs.size(); i++) begin
      a = BASE + 8'(i);
      check("write", {16'd0, obs[i]}, {16'd0, a, payload[i]});
    end
    a = BASE + 8'(n);
    check("done_pulses", done_cnt, ok ? 32'd1 : 32'd0);
    check("load_err", {31'd0, load_err}, {31'd0, !ok});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !ok});
    check("addr_after", {24'd0, mem_addr}, {24'd0, a});
    check("rx_ready_after", {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned len;
    bit          bad;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    payload = {8'h11, 8'h22, 8'h33};
    run_frame(8'd3, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    payload = {8'h7F};
    run_frame(8'd1, 1'b1);
    payload = {8'h01, 8'h02};
    run_frame(8'd2, 1'b0);
`endif

    obs.delete();
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    idle(3);
    check("noise_writes", obs.size(), 32'd0);
    check("noise_err", {31'd0, load_err}, 32'd0);
    check("noise_hold", {31'd0, cpu_hold}, 32'd0);
    payload = {8'hC0, 8'hDE};
    run_frame(8'd2, 1'b0);

    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(8'(i));
    run_frame(8'd0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      payload.delete();
      len = $urandom_range(1, 24);
      for (int unsigned i = 0; i < len; i++)
        payload.push_back(($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom));
      bad = ($urandom_range(0, 3) == 0);
      run_frame(8'(len), bad);
    end

    obs.delete();
    done_cnt = 0;
    send(SYNC);
    send(8'd2);
    send(8'h11);
    n = 0;
    while (!load_err && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("to_err", {31'd0, load_err}, 32'd1);
    check("to_latency", {31'd0, (n >= 16 && n <= 18)}, 32'd1);
    check("to_writes", obs.size(), 32'd1);
    check("to_hold", {31'd0, cpu_hold}, 32'd1);
    check("to_done", done_cnt, 32'd0);

    send(SYNC);
    send(8'd5);
    send(8'h01);
    send(8'h02);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    payload = {8'hAA, 8'hBB, 8'hCC};
    run_frame(8'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
